// File: rtl/vram_write_buffer_pkg.sv
// Shared definitions for the VRAM posted-write buffer.
// Optional feature macro: VRAM_WBUF_COALESCE_EN (store coalescing on the newest entry).
package vram_write_buffer_pkg;

  // Default VRAM geometry
  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 16;
  localparam int VRAM_DEPTH  = 8;

  // Drain FSM encodings
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } wbuf_state_e;

  // Occupancy counter width: must represent 0..depth inclusive
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vram_write_buffer_if.sv
// CPU-store / VRAM-write bus bundle for the VRAM posted-write buffer.
// master = CPU/VGA side that drives stores and blanking, slave = the buffer.
interface vram_write_buffer_if
  import vram_write_buffer_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH  = VRAM_DEPTH
) ();

  localparam int LVL_W = lvl_width(DEPTH);

  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_full;
  logic              vga_blank;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_data;
  logic              ovf;
  logic [LVL_W-1:0]  level;

  modport master (
    output cpu_we, cpu_addr, cpu_data, vga_blank,
    input  cpu_full, vram_we, vram_addr, vram_data, ovf, level
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_data, vga_blank,
    output cpu_full, vram_we, vram_addr, vram_data, ovf, level
  );

endinterface

// File: rtl/vram_write_buffer_sync_fifo.sv
// Synchronous FIFO for the VRAM write buffer: push at tail, pop at head,
// occupancy counter, plus an overwrite port on the newest (tail-1) entry
// used for store coalescing. The caller never pushes and overwrites together.
module vram_write_buffer_sync_fifo
  import vram_write_buffer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KEY_W = 16,
  parameter int DEPTH = 8,
  parameter int LVL_W = lvl_width(DEPTH)
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             ovw,
  input  logic [WIDTH-1:0] ovw_data,
  output logic [WIDTH-1:0] head_data,
  output logic [KEY_W-1:0] tail_key,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] tail_ptr_s;
  logic [LVL_W-1:0] level_r;

  assign tail_ptr_s = wr_ptr_r - PTR_W'(1);
  assign head_data  = mem_r[rd_ptr_r];
  assign tail_key   = mem_r[tail_ptr_s][WIDTH-1 -: KEY_W];
  assign level      = level_r;

  // Storage array: new entry at tail, or in-place rewrite of the newest entry
  always_ff @(posedge clki) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end else if (ovw) begin
      mem_r[tail_ptr_s] <= ovw_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); level tracks occupancy
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      level_r  <= LVL_W'(0);
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/vram_write_buffer.sv
// Posted-write buffer between the CPU bus and the VGA framebuffer write port.
// CPU stores are queued and drained into VRAM one per clock, only while the
// VGA timing reports blanking. Optional macro VRAM_WBUF_COALESCE_EN merges a
// store into the newest queued entry when the addresses match.
module vram_write_buffer
  import vram_write_buffer_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH  = VRAM_DEPTH
) (
  input logic             clki,
  input logic             rst,
  vram_write_buffer_if.slave bus
);

  localparam int LVL_W = lvl_width(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;

  wbuf_state_e       state_r;
  wbuf_state_e       state_nxt_s;
  logic [LVL_W-1:0]  level_s;
  logic [LVL_W-1:0]  lvl_after_s;
  logic [ENT_W-1:0]  head_s;
  logic [ADDR_W-1:0] tail_addr_s;
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              coal_s;
  logic              drop_s;
  logic              vram_we_r;
  logic [ADDR_W-1:0] vram_addr_r;
  logic [DATA_W-1:0] vram_data_r;
  logic              ovf_r;

  vram_write_buffer_sync_fifo #(
    .WIDTH (ENT_W),
    .KEY_W (ADDR_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clki      (clki),
    .rst       (rst),
    .push      (push_s),
    .push_data ({bus.cpu_addr, bus.cpu_data}),
    .pop       (pop_s),
    .ovw       (coal_s),
    .ovw_data  ({bus.cpu_addr, bus.cpu_data}),
    .head_data (head_s),
    .tail_key  (tail_addr_s),
    .level     (level_s)
  );

`ifndef VRAM_WBUF_COALESCE_EN
  logic tail_unused_s;
  assign tail_unused_s = ^tail_addr_s;
`endif

  // Store admission: pop, coalesce, push or drop for the current cycle
  always_comb begin
    full_s = (level_s == LVL_W'(DEPTH));
    pop_s  = (state_r == ST_ISSUE) && (level_s != LVL_W'(0));
`ifdef VRAM_WBUF_COALESCE_EN
    // The newest entry is only safe to rewrite if it is not leaving this cycle
    coal_s = bus.cpu_we && (level_s != LVL_W'(0)) && (tail_addr_s == bus.cpu_addr) &&
             !(pop_s && (level_s == LVL_W'(1)));
`else
    coal_s = 1'b0;
`endif
    push_s      = bus.cpu_we && !coal_s && (!full_s || pop_s);
    drop_s      = bus.cpu_we && !coal_s && full_s && !pop_s;
    lvl_after_s = level_s + LVL_W'(push_s) - LVL_W'(pop_s);
  end

  // Drain FSM next state: keep issuing while blanking and entries remain
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((level_s != LVL_W'(0)) && bus.vga_blank) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if ((lvl_after_s != LVL_W'(0)) && bus.vga_blank) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Drain FSM state register
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // VRAM write port registers (hold last write) and sticky overflow flag
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      vram_we_r   <= 1'b0;
      vram_addr_r <= ADDR_W'(0);
      vram_data_r <= DATA_W'(0);
      ovf_r       <= 1'b0;
    end else begin
      vram_we_r <= pop_s;
      if (pop_s) begin
        vram_addr_r <= head_s[ENT_W-1 -: ADDR_W];
        vram_data_r <= head_s[DATA_W-1:0];
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign bus.cpu_full  = full_s;
  assign bus.vram_we   = vram_we_r;
  assign bus.vram_addr = vram_addr_r;
  assign bus.vram_data = vram_data_r;
  assign bus.ovf       = ovf_r;
  assign bus.level     = level_s;

endmodule

// File: tb/tb_vram_write_buffer.sv
// Self-checking bench for vram_write_buffer: scoreboard of expected VRAM writes
// filled when stores are driven, drained by a monitor on VRAM write strobes.
module tb_vram_write_buffer;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic clki = 1'b0;
  logic rst  = 1'b1;
  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;
  int   wr_cnt;
  int   n;

  vram_write_buffer_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) bus ();

  vram_write_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clki (clki),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clki = ~clki;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every VRAM write must match the oldest expected store
  always @(negedge clki) begin
    if (!rst && bus.vram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", {bus.vram_addr, bus.vram_data}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_write", {bus.vram_addr, bus.vram_data}, mon_e);
      end
    end
  end

  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cpu_we = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d, input bit exp_push);
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_data = d;
    if (exp_push) exp_q.push_back({a, d});
    tick();
    bus.cpu_we = 1'b0;
  endtask

  task automatic drain_wait(input string tag, input int budget);
    int k;
    k = 0;
    while (bus.level != 4'd0 && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_drain_timeout"}, 32'(k < budget), 32'd1);
    tick();
    tick();
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0;
    bus.cpu_data  = 16'h0;
    bus.vga_blank = 1'b0;
    tick();
    tick();
    check("rst_level",    32'(bus.level),     32'd0);
    check("rst_full",     32'(bus.cpu_full),  32'd0);
    check("rst_vram_we",  32'(bus.vram_we),   32'd0);
    check("rst_vram_adr", 32'(bus.vram_addr), 32'd0);
    check("rst_vram_dat", 32'(bus.vram_data), 32'd0);
    check("rst_ovf",      32'(bus.ovf),       32'd0);
    rst = 1'b0;
    tick();

    // T1: reset in the middle of a drain with 5 queued stores
    for (int i = 0; i < 5; i++) store(16'h0040 + 16'(i), 16'h5000 + 16'(i), 1'b1);
    check("t1_level5", 32'(bus.level), 32'd5);
    bus.vga_blank = 1'b1;
    tick();
    tick();
    tick();
    check("t1_mid_drain", 32'(bus.vram_we), 32'd1);
    rst = 1'b1;
    #1;
    check("t1_rst_we",    32'(bus.vram_we), 32'd0);
    check("t1_rst_level", 32'(bus.level),   32'd0);
    check("t1_rst_ovf",   32'(bus.ovf),     32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();

    // T2: single store during blanking, two-cycle latency
    store(16'h0010, 16'hBEEF, 1'b1);
    check("t2_lat0", 32'(bus.vram_we), 32'd0);
    tick();
    check("t2_lat1", 32'(bus.vram_we), 32'd0);
    tick();
    check("t2_lat2_we",   32'(bus.vram_we),   32'd1);
    check("t2_lat2_addr", 32'(bus.vram_addr), 32'h0010);
    check("t2_lat2_data", 32'(bus.vram_data), 32'hBEEF);
    tick();
    check("t2_one_cycle", 32'(bus.vram_we),   32'd0);
    check("t2_hold_data", 32'(bus.vram_data), 32'hBEEF);

    // T3: fill, overflow drop, then back-to-back drain
    do_reset();
    bus.vga_blank = 1'b0;
    for (int i = 0; i < 8; i++) store(16'h0100 + 16'(i), 16'hA000 + 16'(i), 1'b1);
    check("t3_full",   32'(bus.cpu_full), 32'd1);
    check("t3_level8", 32'(bus.level),    32'd8);
    check("t3_no_ovf", 32'(bus.ovf),      32'd0);
    store(16'h01FF, 16'hDEAD, 1'b0);
    check("t3_ovf",        32'(bus.ovf),   32'd1);
    check("t3_level_drop", 32'(bus.level), 32'd8);
    bus.vga_blank = 1'b1;
    n = 0;
    while (bus.vram_we !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("t3_first_write", 32'(n < 10), 32'd1);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("t3_b2b", 32'(bus.vram_we), 32'd1);
    end
    tick();
    check("t3_end_we",   32'(bus.vram_we),  32'd0);
    check("t3_end_full", 32'(bus.cpu_full), 32'd0);
    check("t3_end_lvl",  32'(bus.level),    32'd0);
    check("t3_ovf_hold", 32'(bus.ovf),      32'd1);
    tick();
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // T4: blanking ends mid-drain; in-flight write completes
    do_reset();
    bus.vga_blank = 1'b0;
    for (int i = 0; i < 6; i++) store(16'h0200 + 16'(i), 16'hB000 + 16'(i), 1'b1);
    bus.vga_blank = 1'b1;
    wr_cnt = 0;
    n = 0;
    while (wr_cnt < 3 && n < 20) begin
      tick();
      n++;
      if (bus.vram_we === 1'b1) wr_cnt++;
    end
    bus.vga_blank = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.vram_we === 1'b1) wr_cnt++;
    end
    check("t4_partial_cnt", 32'(wr_cnt == 3 || wr_cnt == 4), 32'd1);
    check("t4_level_rem",   32'(bus.level), 32'(6 - wr_cnt));
    bus.vga_blank = 1'b1;
    drain_wait("t4", 20);

    // T5: store on a full FIFO coinciding with a pop is accepted
    do_reset();
    bus.vga_blank = 1'b0;
    for (int i = 0; i < 8; i++) store(16'h0300 + 16'(i), 16'hC000 + 16'(i), 1'b1);
    bus.vga_blank = 1'b1;
    tick();
    store(16'h03AA, 16'hC0DE, 1'b1);
    check("t5_level8", 32'(bus.level),    32'd8);
    check("t5_no_ovf", 32'(bus.ovf),      32'd0);
    check("t5_we",     32'(bus.vram_we),  32'd1);
    check("t5_full",   32'(bus.cpu_full), 32'd1);
    drain_wait("t5", 20);
    check("t5_ovf_end", 32'(bus.ovf), 32'd0);

    // T6: duplicate address stores
    do_reset();
    bus.vga_blank = 1'b0;
    store(16'h0020, 16'h1111, 1'b1);
`ifdef VRAM_WBUF_COALESCE_EN
    store(16'h0020, 16'h2222, 1'b0);
    exp_q[exp_q.size() - 1] = {16'h0020, 16'h2222};
    check("t6_level", 32'(bus.level), 32'd1);
`else
    store(16'h0020, 16'h2222, 1'b1);
    check("t6_level", 32'(bus.level), 32'd2);
`endif
    check("t6_no_ovf", 32'(bus.ovf), 32'd0);
    bus.vga_blank = 1'b1;
    drain_wait("t6", 20);
    check("t6_last_data", 32'(bus.vram_data), 32'h2222);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
